// File: rtl/any1_iline_fetch.sv
// Instruction line fetcher: one tagged 64-byte line buffer. A miss fills the buffer
// with a Wishbone-style burst, then the line is presented with the requesting ip.
module any1_iline_fetch #(
    parameter int LINE_BITS = 512,
    parameter int BUS_BITS  = 128,
    parameter int AWID      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  ip_req_i,
    input  logic [AWID-1:0]       ip_i,
    input  logic [AWID-1:0]       pip_i,
    input  logic                  predict_taken_i,
    output logic [LINE_BITS-1:0]  line_o,
    output logic [AWID-1:0]       ip_o,
    output logic [AWID-1:0]       pip_o,
    output logic                  predict_taken_o,
    output logic                  line_vld_o,
    output logic                  bus_err_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic [BUS_BITS/8-1:0] sel_o,
    output logic [AWID-1:0]       adr_o,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic [BUS_BITS-1:0]   dat_i
);
    // state | meaning
    // IDLE  | evaluate request against the buffered tag; serve hits
    // FILL  | burst in progress, one buffer slot written per ack
    localparam int BEATS = LINE_BITS / BUS_BITS;
    localparam int BW    = $clog2(BEATS);
    localparam int OW    = $clog2(BUS_BITS / 8);
    localparam int TW    = AWID - BW - OW;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]    state;
    logic [TW-1:0] tag;
    logic [TW-1:0] fill_tag;
    logic          tag_vld;
    logic          flushed;
    logic [BW-1:0] beat;
    logic          hit;

    // A flush in the same cycle as a request forces the miss path.
    assign hit   = tag_vld && (tag == ip_i[AWID-1:AWID-TW]) && !flush_i;
    assign cyc_o = (state == FILL);
    assign stb_o = cyc_o;
    assign sel_o = {(BUS_BITS/8){cyc_o}};
    assign adr_o = cyc_o ? {fill_tag, beat, {OW{1'b0}}} : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tag             <= '0;
            fill_tag        <= '0;
            tag_vld         <= 1'b0;
            flushed         <= 1'b0;
            beat            <= '0;
            line_o          <= '0;
            ip_o            <= '0;
            pip_o           <= '0;
            predict_taken_o <= 1'b0;
            line_vld_o      <= 1'b0;
            bus_err_o       <= 1'b0;
        end else begin
            line_vld_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_i)
                        tag_vld <= 1'b0;
                    if (ip_req_i) begin
                        if (hit) begin
                            line_vld_o      <= 1'b1;
                            ip_o            <= ip_i;
                            pip_o           <= pip_i;
                            predict_taken_o <= predict_taken_i;
                        end else begin
                            // Buffer is about to be overwritten, so it cannot stay valid.
                            tag_vld  <= 1'b0;
                            fill_tag <= ip_i[AWID-1:AWID-TW];
                            flushed  <= 1'b0;
                            beat     <= '0;
                            state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (flush_i)
                        flushed <= 1'b1;
                    if (err_i) begin
                        tag_vld         <= 1'b0;
                        line_vld_o      <= 1'b1;
                        bus_err_o       <= 1'b1;
                        ip_o            <= ip_i;
                        pip_o           <= pip_i;
                        predict_taken_o <= predict_taken_i;
                        beat            <= '0;
                        state           <= IDLE;
                    end else if (ack_i) begin
                        line_o[int'(beat)*BUS_BITS +: BUS_BITS] <= dat_i;
                        if (beat == BW'(BEATS-1)) begin
                            tag     <= fill_tag;
                            tag_vld <= !(flushed || flush_i);
                            beat    <= '0;
                            state   <= IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
